// File: rtl/mem_request_ctrl.sv
// Request sequencer between control/datapath and the cache interface: fetch, one data
// access per instruction, PC enable, halt drain, optional access timeout and access count.
module mem_request_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt_in,
    input  logic              dreq_rd,
    input  logic              dreq_wr,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic              ihit,
    input  logic              dhit,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              pc_en,
    output logic              halted,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  dreq_count
);
    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, DREQ, HALT} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            expire;

    // wait_cnt holds the number of earlier DREQ cycles, so the TIMEOUT-th cycle expires
    assign expire  = (TIMEOUT > 0) && (state == DREQ) && !dhit &&
                     (wait_cnt == WC_W'(TIMEOUT - 1));
    assign imemREN = (state == IDLE);
    assign pc_en   = ((state == IDLE) && ihit && !halt_in && !(dreq_rd || dreq_wr)) ||
                     ((state == DREQ) && (dhit || expire));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            dreq_count  <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ihit) begin
                        if (halt_in) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (dreq_rd || dreq_wr) begin
                            dmemaddr  <= daddr;
                            dmemstore <= dstore;
                            dmemREN   <= dreq_rd & ~dreq_wr;
                            dmemWEN   <= dreq_wr;
                            wait_cnt  <= '0;
                            state     <= DREQ;
                        end
                    end
                end
                DREQ: begin
                    if (dhit) begin
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        if (dreq_count != '1)
                            dreq_count <= dreq_count + 1'b1;
                        state <= IDLE;
                    end else if (expire) begin
                        dmemREN     <= 1'b0;
                        dmemWEN     <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALT: begin
                    halted  <= 1'b1;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed bench: dut0 uses defaults (no timeout), dut1 has TIMEOUT=4 and a 2-bit counter.
module tb_mem_request_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        halt_in = 0, dreq_rd = 0, dreq_wr = 0, ihit = 0, dhit = 0;
    logic [31:0] daddr = 0, dstore = 0;

    logic        imemREN0, dmemREN0, dmemWEN0, pc_en0, halted0, terr0;
    logic [31:0] dmemaddr0, dmemstore0;
    logic [15:0] cnt0;
    logic        imemREN1, dmemREN1, dmemWEN1, pc_en1, halted1, terr1;
    logic [31:0] dmemaddr1, dmemstore1;
    logic [1:0]  cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_request_ctrl dut0 (
        .CLK(CLK), .RST(RST), .halt_in(halt_in), .dreq_rd(dreq_rd), .dreq_wr(dreq_wr),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
        .imemREN(imemREN0), .dmemREN(dmemREN0), .dmemWEN(dmemWEN0),
        .dmemaddr(dmemaddr0), .dmemstore(dmemstore0), .pc_en(pc_en0),
        .halted(halted0), .timeout_err(terr0), .dreq_count(cnt0)
    );

    mem_request_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut1 (
        .CLK(CLK), .RST(RST), .halt_in(halt_in), .dreq_rd(dreq_rd), .dreq_wr(dreq_wr),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
        .imemREN(imemREN1), .dmemREN(dmemREN1), .dmemWEN(dmemWEN1),
        .dmemaddr(dmemaddr1), .dmemstore(dmemstore1), .pc_en(pc_en1),
        .halted(halted1), .timeout_err(terr1), .dreq_count(cnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change 1ns after the rising edge; checks happen 2ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        halt_in = 0; dreq_rd = 0; dreq_wr = 0; ihit = 0; dhit = 0;
        daddr = 32'h999; dstore = 32'h0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_ren", dmemREN0, 0);
        check("rst_terr1", terr1, 0);
        check("rst_cnt0", cnt0, 0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_imem", imemREN0, 1);
        check("rst_dmem", {dmemREN0, dmemWEN0, dmemREN1, dmemWEN1}, 0);
        check("rst_addr", dmemaddr0, 0);
        check("rst_halt", {halted0, halted1, terr0, terr1}, 0);
        check("rst_cnt", {cnt0, cnt1}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // 1: fetch-only instructions
        for (int i = 0; i < 3; i++) begin
            tick(); clr(); ihit = 1;
            #1;
            check("t1_imem", imemREN0, 1);
            check("t1_pc_hit", {pc_en0, pc_en1}, 2'b11);
            tick(); clr();
            #1;
            check("t1_pc_nohit", {pc_en0, pc_en1}, 0);
        end
        check("t1_cnt", {cnt0, cnt1}, 0);

        // 2: load, dhit on the 4th DREQ cycle
        tick(); clr(); ihit = 1; dreq_rd = 1; daddr = 32'h100;
        #1;
        check("t2_pc_issue", pc_en0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(); clr(); dhit = (k == 4); ihit = 1;
            #1;
            check("t2_ren", {dmemREN0, dmemWEN0}, 2'b10);
            check("t2_addr", dmemaddr0, 32'h100);
            check("t2_imem", imemREN0, 0);
            check("t2_pc", {pc_en0, pc_en1}, (k == 4) ? 2'b11 : 2'b00);
        end
        tick(); clr();
        #1;
        check("t2_drop", {dmemREN0, dmemREN1}, 0);
        check("t2_cnt", {cnt0, 14'd0, cnt1}, {16'd1, 14'd0, 2'd1});
        check("t2_terr1", terr1, 0);

        // 3: read and write together, write wins
        tick(); clr(); ihit = 1; dreq_rd = 1; dreq_wr = 1; dstore = 32'hDEADBEEF;
        tick(); clr(); dhit = 1;
        #1;
        check("t3_wen", {dmemREN0, dmemWEN0}, 2'b01);
        check("t3_data", dmemstore0, 32'hDEADBEEF);
        check("t3_pc", pc_en0, 1);
        tick(); clr();
        #1;
        check("t3_cnt", {cnt0, 14'd0, cnt1}, {16'd2, 14'd0, 2'd2});

        // 4a: store never completes, dut1 times out on its 4th DREQ cycle
        tick(); clr(); ihit = 1; dreq_wr = 1; daddr = 32'h300;
        for (int k = 1; k <= 4; k++) begin
            tick(); clr();
            #1;
            check("t4_wen1", dmemWEN1, 1);
            check("t4_pc1", pc_en1, (k == 4));
            check("t4_terr_early", terr1, 0);
        end
        tick(); clr();
        #1;
        check("t4_terr", terr1, 1);
        check("t4_drop", dmemWEN1, 0);
        check("t4_idle", imemREN1, 1);
        check("t4_cnt1", cnt1, 2);
        check("t4_hung0", {dmemWEN0, terr0}, 2'b10);
        do_reset();

        // 4b: dhit on the expiry cycle completes normally
        tick(); clr(); ihit = 1; dreq_wr = 1;
        for (int k = 1; k <= 4; k++) begin
            tick(); clr(); dhit = (k == 4);
            #1;
            check("t4b_pc1", pc_en1, (k == 4));
        end
        tick(); clr();
        #1;
        check("t4b_terr", terr1, 0);
        check("t4b_cnt1", cnt1, 1);

        // 6a: async reset in the middle of DREQ
        tick(); clr(); ihit = 1; dreq_rd = 1;
        tick(); clr();
        #1;
        check("t6_ren_pre", dmemREN0, 1);
        #1;
        RST = 1'b1;
        #1;
        check("t6_ren_async", {dmemREN0, dmemREN1}, 0);
        check("t6_cnt", {cnt0, cnt1}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // 6b: counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            tick(); clr(); ihit = 1; dreq_rd = 1;
            tick(); clr(); dhit = 1;
            tick(); clr();
        end
        #1;
        check("t6_sat0", cnt0, 5);
        check("t6_sat1", cnt1, 3);

        // 5: halt is absorbing
        tick(); clr(); ihit = 1; halt_in = 1;
        #1;
        check("t5_pc", pc_en0, 0);
        tick(); clr();
        #1;
        check("t5_halted", {halted0, halted1}, 2'b11);
        check("t5_reqs", {imemREN0, dmemREN0, dmemWEN0}, 0);
        tick(); clr(); ihit = 1; dreq_rd = 1; dhit = 1;
        #1;
        check("t5_pc_ign", {pc_en0, pc_en1}, 0);
        tick(); clr();
        #1;
        check("t5_still", {halted0, imemREN0, dmemREN0}, 3'b100);
        check("t5_cnt", cnt0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
